// File: rtl/mul_div_arb.sv
// mul_div_arb: round-robin arbiter that shares one multi-cycle mul_div unit
// between two valid/ready requesters and returns each result, tagged with
// the issuing requester's id, on a single response channel.
module mul_div_arb #(
  parameter int N   = 10,
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic             req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_r,
  output logic [4:0]       rsp_flags,
  output logic             rsp_id,
  output logic [N-1:0]     md_a,
  output logic [N-1:0]     md_b,
  output logic             md_sel,
  output logic             md_en,
  output logic             md_arst,
  input  logic [2*N-1:0]   md_r,
  input  logic [4:0]       md_flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [N-1:0]     md_a_q, md_a_d;
  logic [N-1:0]     md_b_q, md_b_d;
  logic             md_sel_q, md_sel_d;
  logic             md_en_q, md_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2*N-1:0]   rsp_r_q, rsp_r_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_id_q, rsp_id_d;
  logic             gnt0_s, gnt1_s;

  // Grant decision: only in IDLE and out of reset; prio breaks ties.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if ((state_q == IDLE) && srst_n) begin
      if (req0_valid && req1_valid) begin
        if (prio_q) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0_s = 1'b1;
      end else if (req1_valid) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    id_d        = id_q;
    md_a_d      = md_a_q;
    md_b_d      = md_b_q;
    md_sel_d    = md_sel_q;
    md_en_d     = md_en_q;
    rsp_valid_d = rsp_valid_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        // ready equals grant, so a grant with valid is the handshake
        if (gnt0_s || gnt1_s) begin
          md_a_d   = gnt1_s ? req1_a : req0_a;
          md_b_d   = gnt1_s ? req1_b : req0_b;
          md_sel_d = gnt1_s ? req1_sel : req0_sel;
          id_d     = gnt1_s;
          prio_d   = ~gnt1_s;
          md_en_d  = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          rsp_r_d     = md_r;
          rsp_flags_d = md_flags;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          md_en_d     = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        md_en_d     = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      md_a_q      <= {N{1'b0}};
      md_b_q      <= {N{1'b0}};
      md_sel_q    <= 1'b0;
      md_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= {(2*N){1'b0}};
      rsp_flags_q <= 5'b00000;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      id_q        <= id_d;
      md_a_q      <= md_a_d;
      md_b_q      <= md_b_d;
      md_sel_q    <= md_sel_d;
      md_en_q     <= md_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_id     = rsp_id_q;
  assign md_a       = md_a_q;
  assign md_b       = md_b_q;
  assign md_sel     = md_sel_q;
  assign md_en      = md_en_q;
  assign md_arst    = ~srst_n;

endmodule

// File: tb/tb_mul_div_arb.sv
// tb_mul_div_arb: drives both requesters, models the mul_div unit as a
// LAT-deep enabled pipeline, and compares every DUT output each cycle
// against a transaction-level reference (phase + age since grant).
module tb_mul_div_arb;
  localparam int N   = 10;
  localparam int LAT = 2;

  logic           clk;
  logic           srst_n;
  logic           req0_valid, req0_ready, req0_sel;
  logic [N-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready, req1_sel;
  logic [N-1:0]   req1_a, req1_b;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [2*N-1:0] rsp_r;
  logic [4:0]     rsp_flags;
  logic [N-1:0]   md_a, md_b;
  logic           md_sel, md_en, md_arst;
  logic [2*N-1:0] md_r;
  logic [4:0]     md_flags;

  mul_div_arb #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .srst_n(srst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
    .rsp_flags(rsp_flags), .rsp_id(rsp_id),
    .md_a(md_a), .md_b(md_b), .md_sel(md_sel), .md_en(md_en),
    .md_arst(md_arst), .md_r(md_r), .md_flags(md_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbitrary but deterministic mul_div behaviour: {flags, R}.
  function automatic logic [2*N+4:0] fmd(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic sel);
    logic [2*N-1:0] r;
    logic [4:0]     f;
    if (sel) begin
      r = {b, a} ^ 20'h5A5A5;
      f = (b == 10'd0) ? 5'b01000 : {a[N-1] & b[N-1], 1'b0, a[0] & b[0], ~|a, 1'b1};
    end else begin
      r = 20'(a) * 20'(b);
      f = {a[N-1] & b[N-1], 1'b0, a[0] & b[0], ~|a, 1'b0};
    end
    return {f, r};
  endfunction

  // mul_div model: result appears LAT enabled edges after operands; filler otherwise.
  logic [2*N+4:0] pipe [LAT];
  always @(posedge clk) begin
    if (md_arst || !md_en) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '1;
    end else begin
      pipe[0] <= fmd(md_a, md_b, md_sel);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign md_flags = pipe[LAT-1][2*N+4:2*N];
  assign md_r     = pipe[LAT-1][2*N-1:0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state (value after the most recent clock edge)
  int             m_phase;   // 0 idle, 1 operation in flight, 2 response held
  int             m_age;
  logic           m_prio;
  logic [N-1:0]   m_a, m_b;
  logic           m_sel;
  logic [2*N-1:0] m_r, p_r;
  logic [4:0]     m_fl, p_fl;
  logic           m_id, p_id;
  int             left0, left1;
  bit             need_new0, need_new1, rnd_valid;
  int             rr_mode;   // 0 never ready, 1 always ready, 2 random
  int             grants[$];

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_prio = 1'b0;
    m_a = '0; m_b = '0; m_sel = 1'b0;
    m_r = '0; m_fl = '0; m_id = 1'b0;
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance model, wait.
  task automatic step();
    int w;
    if (need_new0) begin
      req0_a = N'($urandom); req0_b = N'($urandom); req0_sel = 1'($urandom); need_new0 = 0;
    end
    if (need_new1) begin
      req1_a = N'($urandom); req1_b = N'($urandom); req1_sel = 1'($urandom); need_new1 = 0;
    end
    req0_valid = (left0 > 0) && (!rnd_valid || ($urandom_range(0, 3) != 0));
    req1_valid = (left1 > 0) && (!rnd_valid || ($urandom_range(0, 3) != 0));
    rsp_ready  = (rr_mode == 1) ? 1'b1 : (rr_mode == 0) ? 1'b0 : 1'($urandom);
    #1;
    w = -1;
    if (m_phase == 0 && srst_n) begin
      if (req0_valid && req1_valid) w = int'(m_prio);
      else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
    end
    check_val("ready", {req1_ready, req0_ready}, {w == 1, w == 0});
    check_val("rsp_valid", rsp_valid, m_phase == 2);
    check_val("rsp_r", rsp_r, m_r);
    check_val("rsp_flags", rsp_flags, m_fl);
    check_val("rsp_id", rsp_id, m_id);
    check_val("md_a", md_a, m_a);
    check_val("md_b", md_b, m_b);
    check_val("md_sel", md_sel, m_sel);
    check_val("md_en", md_en, m_phase == 1);
    check_val("md_arst", md_arst, !srst_n);
    if (!srst_n) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (w >= 0) begin
          m_a   = (w == 1) ? req1_a : req0_a;
          m_b   = (w == 1) ? req1_b : req0_b;
          m_sel = (w == 1) ? req1_sel : req0_sel;
          {p_fl, p_r} = fmd(m_a, m_b, m_sel);
          p_id = (w == 1);
          m_prio = (w == 0);
          m_phase = 1; m_age = 0;
          grants.push_back(w);
          if (w == 1) begin left1--; need_new1 = 1; end
          else begin left0--; need_new0 = 1; end
        end
        1: begin
          m_age++;
          if (m_age == LAT + 1) begin
            m_phase = 2; m_r = p_r; m_fl = p_fl; m_id = p_id;
          end
        end
        2: if (rsp_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((left0 > 0 || left1 > 0 || m_phase != 0) && k < budget) begin
      step();
      k++;
    end
    check_val("drain_done", left0 + left1 + m_phase, 0);
  endtask

  task automatic wait_phase(input int ph, input int age, input int budget);
    int k = 0;
    while (!(m_phase == ph && m_age == age) && k < budget) begin
      step();
      k++;
    end
    check_val("reach_phase", (m_phase == ph && m_age == age), 1);
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    step();
    step();
    srst_n = 1'b1;
  endtask

  initial begin
    srst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = 1'b0;
    left0 = 0; left1 = 0; need_new0 = 1; need_new1 = 1; rnd_valid = 0; rr_mode = 1;
    model_reset();
    repeat (2) @(negedge clk);

    // T1: reset then a single directed multiply from requester 0
    do_reset();
    need_new0 = 0; req0_a = 10'h3C0; req0_b = 10'h200; req0_sel = 1'b0;
    left0 = 1;
    drain(40);

    // T2: both requesters contend for four ops; grants must alternate from 0
    do_reset();
    grants.delete();
    left0 = 2; left1 = 2;
    drain(80);
    check_val("t2_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check_val("t2_order", grants[i], i % 2);

    // T3: consumer stalls five cycles with another request pending
    rr_mode = 0;
    left0 = 1;
    wait_phase(2, LAT + 1, 40);
    left1 = 1;
    repeat (5) step();
    rr_mode = 1;
    drain(60);

    // T4: divide by zero from requester 1
    need_new1 = 0; req1_a = N'($urandom); req1_b = 10'h000; req1_sel = 1'b1;
    left1 = 1;
    rr_mode = 0;
    wait_phase(2, LAT + 1, 40);
    check_val("t4_dz", rsp_flags, 5'b01000);
    check_val("t4_id", rsp_id, 1);
    rr_mode = 1;
    drain(40);

    // T5: reset while waiting on mul_div, then both request; 0 must win
    left1 = 1;
    wait_phase(1, 2, 40);
    left1 = 0;
    srst_n = 1'b0;
    step();
    step();
    srst_n = 1'b1;
    grants.delete();
    left0 = 1; left1 = 1;
    drain(60);
    check_val("t5_first", (grants.size() > 0) ? grants[0] : -1, 0);

    // T6: only requester 1, three times in a row
    grants.delete();
    left1 = 3;
    drain(80);
    check_val("t6_count", grants.size(), 3);
    foreach (grants[i]) check_val("t6_id", grants[i], 1);

    // Random traffic: flickering valids and a random consumer
    rnd_valid = 1; rr_mode = 2;
    left0 = 25; left1 = 25;
    drain(3000);
    rnd_valid = 0; rr_mode = 1;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
